// File: rtl/deint_line_sched.sv
// rtl/deint_line_sched.sv - read-side scheduler for the deinterlacer's two line FIFOs
// Optional FIFO-empty guarding and sticky underflow flag: DEINT_SCHED_EMPTY_CHK_EN
module deint_line_sched #(
  parameter int WIDTH       = 720,
  parameter int HALF_HEIGHT = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ready_to_continue,
  output logic       aver_sent,
  output logic       rd_req0,
  output logic       rd_req1,
  output logic       recirc_wr0,
  output logic       recirc_wr1,
  output logic [1:0] out_sel,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_startofpacket,
  output logic       dout_endofpacket
`ifdef DEINT_SCHED_EMPTY_CHK_EN
  ,
  input  logic       empty0,
  input  logic       empty1,
  output logic       underflow_err
`endif
);

  localparam logic [9:0] PX_LAST   = 10'(WIDTH - 1);
  localparam logic [9:0] PAIR_LAST = 10'(HALF_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ORIG,
    AVER,
    TAIL_A,
    TAIL_B
  } state_t;

  state_t     state;
  logic       older;      // 0: buffer 0 holds the older line
  logic [9:0] px;
  logic [9:0] pair_cnt;
  logic       hdr_done;

  logic       line_end;
  logic       beat;
  logic       blocked;
  logic       st_valid;
  logic [1:0] st_sel;
  logic       pop_old;
  logic       pop_new;
  logic       rec_old;
  logic       rec_new;
  logic       pop0;
  logic       pop1;
  logic       rec0;
  logic       rec1;

  assign line_end = (px == PX_LAST);

  // Per-state role of the older/newer buffers; mapped to physical FIFOs below.
  always_comb begin
    st_valid = 1'b0;
    st_sel   = 2'd0;
    pop_old  = 1'b0;
    pop_new  = 1'b0;
    rec_old  = 1'b0;
    rec_new  = 1'b0;
    case (state)
      HDR: begin
        st_valid = 1'b1;
        st_sel   = 2'd0;
      end
      ORIG: begin
        st_valid = 1'b1;
        st_sel   = 2'd1;
        pop_old  = 1'b1;
        rec_old  = 1'b1;
      end
      AVER: begin
        st_valid = 1'b1;
        st_sel   = 2'd2;
        pop_old  = 1'b1;
        pop_new  = 1'b1;
        rec_new  = 1'b1;
      end
      TAIL_A: begin
        st_valid = 1'b1;
        st_sel   = 2'd3;
        pop_new  = 1'b1;
        rec_new  = 1'b1;
      end
      TAIL_B: begin
        st_valid = 1'b1;
        st_sel   = 2'd3;
        pop_new  = 1'b1;
      end
      default: begin
        st_valid = 1'b0;
      end
    endcase
  end

  assign pop0 = older ? pop_new : pop_old;
  assign pop1 = older ? pop_old : pop_new;
  assign rec0 = older ? rec_new : rec_old;
  assign rec1 = older ? rec_old : rec_new;

`ifdef DEINT_SCHED_EMPTY_CHK_EN
  assign blocked = (pop0 & empty0) | (pop1 & empty1);
`else
  assign blocked = 1'b0;
`endif

  assign dout_valid         = st_valid & ~blocked;
  assign beat               = dout_valid & dout_ready;
  assign out_sel            = st_sel;
  assign rd_req0            = beat & pop0;
  assign rd_req1            = beat & pop1;
  assign recirc_wr0         = beat & rec0;
  assign recirc_wr1         = beat & rec1;
  assign dout_startofpacket = (state == HDR);
  assign dout_endofpacket   = (state == TAIL_B) & line_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      older     <= 1'b0;
      px        <= '0;
      pair_cnt  <= '0;
      hdr_done  <= 1'b0;
      aver_sent <= 1'b0;
    end else begin
      aver_sent <= 1'b0;
      if (beat && state != HDR) begin
        px <= line_end ? 10'd0 : px + 10'd1;
      end
      case (state)
        IDLE: begin
          // The sink is still lowering ready_to_continue while aver_sent is high.
          if (ready_to_continue && !aver_sent) begin
            state <= hdr_done ? ORIG : HDR;
          end
        end
        HDR: begin
          if (beat) begin
            hdr_done <= 1'b1;
            state    <= ORIG;
          end
        end
        ORIG: begin
          if (beat && line_end) begin
            if (HALF_HEIGHT == 1) begin
              // Single-line field: replay the recirculated line as the newer buffer.
              older <= ~older;
              state <= TAIL_B;
            end else begin
              state <= AVER;
            end
          end
        end
        AVER: begin
          if (beat && line_end) begin
            pair_cnt <= pair_cnt + 10'd1;
            if (pair_cnt + 10'd1 == PAIR_LAST) begin
              state <= TAIL_A;
            end else begin
              aver_sent <= 1'b1;
              older     <= ~older;
              state     <= IDLE;
            end
          end
        end
        TAIL_A: begin
          if (beat && line_end) begin
            state <= TAIL_B;
          end
        end
        TAIL_B: begin
          if (beat && line_end) begin
            aver_sent <= 1'b1;
            older     <= 1'b0;
            pair_cnt  <= '0;
            hdr_done  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DEINT_SCHED_EMPTY_CHK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_err <= 1'b0;
    end else if ((rd_req0 & empty0) | (rd_req1 & empty1)) begin
      underflow_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_deint_line_sched.sv
// tb/tb_deint_line_sched.sv - self-checking bench for deint_line_sched
// Line-order reference model with behavioural FIFOs driven by the DUT strobes.
module tb_deint_line_sched;
  localparam int W = 4;
  localparam int H = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ready_to_continue = 1'b0;
  logic       dout_ready = 1'b1;
  logic       aver_sent;
  logic       rd_req0;
  logic       rd_req1;
  logic       recirc_wr0;
  logic       recirc_wr1;
  logic [1:0] out_sel;
  logic       dout_valid;
  logic       sop;
  logic       eop;

  deint_line_sched #(.WIDTH(W), .HALF_HEIGHT(H)) dut (
    .clock              (clock),
    .reset              (reset),
    .ready_to_continue  (ready_to_continue),
    .aver_sent          (aver_sent),
    .rd_req0            (rd_req0),
    .rd_req1            (rd_req1),
    .recirc_wr0         (recirc_wr0),
    .recirc_wr1         (recirc_wr1),
    .out_sel            (out_sel),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (sop),
    .dout_endofpacket   (eop)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sel;
    int sop;
    int eop;
    int data;
  } beat_t;

  beat_t      got[$];
  beat_t      exp_q[$];
  int         q0[$];
  int         q1[$];
  int         ln[H][W];
  int         total = 0;
  int         bad = 0;
  int         n_aver = 0;
  bit         prev_stall = 0;
  logic [1:0] prev_sel = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_lines();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) ln[i][j] = int'($urandom_range(0, 255));
  endtask

  task automatic load(input int fifo, input int line);
    for (int j = 0; j < W; j++) begin
      if (fifo == 0) q0.push_back(ln[line][j]);
      else q1.push_back(ln[line][j]);
    end
  endtask

  // Field order: L0, avg(L0,L1), L1, ..., L(H-1), L(H-1), after one header word.
  task automatic build_exp();
    beat_t b;
    exp_q.delete();
    b.sel = 0; b.sop = 1; b.eop = 0; b.data = 0;
    exp_q.push_back(b);
    for (int k = 0; k < 2 * H; k++) begin
      for (int j = 0; j < W; j++) begin
        b.sop = 0;
        b.eop = (k == 2 * H - 1 && j == W - 1) ? 1 : 0;
        if (k >= 2 * H - 2) begin
          b.sel = 3; b.data = ln[H-1][j];
        end else if (k % 2 == 0) begin
          b.sel = 1; b.data = ln[k/2][j];
        end else begin
          b.sel = 2; b.data = (ln[k/2][j] + ln[k/2+1][j]) / 2;
        end
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic int n_sel2();
    int n = 0;
    foreach (got[i]) if (got[i].sel == 2) n++;
    return n;
  endfunction

  task automatic observe();
    int a;
    int b;
    int d;
    beat_t r;
    if (prev_stall) begin
      check("stall_hold_valid", dout_valid, 1);
      check("stall_hold_sel", out_sel, prev_sel);
    end
    if (!dout_ready) check("stall_no_strobe", {rd_req0, rd_req1, recirc_wr0, recirc_wr1}, 0);
    if (aver_sent) n_aver++;
    if (dout_valid && dout_ready) begin
      a = -1;
      b = -1;
      if (rd_req0) begin
        check("pop0_nonempty", q0.size() > 0, 1);
        if (q0.size() > 0) a = q0.pop_front();
      end
      if (rd_req1) begin
        check("pop1_nonempty", q1.size() > 0, 1);
        if (q1.size() > 0) b = q1.pop_front();
      end
      if (recirc_wr0) q0.push_back(rd_req0 ? a : -1);
      if (recirc_wr1) q1.push_back(rd_req1 ? b : -1);
      case (out_sel)
        2'd0:    d = (rd_req0 || rd_req1) ? -1 : 0;
        2'd2:    d = (rd_req0 && rd_req1) ? (a + b) / 2 : -1;
        default: d = (rd_req0 ^ rd_req1) ? (rd_req0 ? a : b) : -1;
      endcase
      r.sel = int'(out_sel); r.sop = int'(sop); r.eop = int'(eop); r.data = d;
      got.push_back(r);
    end
    prev_stall = dout_valid && !dout_ready;
    prev_sel = out_sel;
  endtask

  // The sink reacts to aver_sent one edge later, as a registered sink would.
  task automatic cyc();
    bit saw;
    #1;
    observe();
    saw = aver_sent;
    @(posedge clock);
    #1;
    if (saw) ready_to_continue = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check("idle_no_valid", dout_valid, 0);
      observe();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_handshake(input bit hold_rtc, input bit rnd, input int bound);
    int n0;
    int c;
    n0 = n_aver;
    c = 0;
    ready_to_continue = 1'b1;
    while (n_aver == n0 && c < bound) begin
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!hold_rtc && c == 1) ready_to_continue = 1'b0;
      cyc();
      c++;
    end
    check("handshake_done", n_aver - n0, 1);
    ready_to_continue = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic compare_frame();
    check("frame_beats", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("sel[%0d]", i), got[i].sel, exp_q[i].sel);
      check($sformatf("sop[%0d]", i), got[i].sop, exp_q[i].sop);
      check($sformatf("eop[%0d]", i), got[i].eop, exp_q[i].eop);
      check($sformatf("data[%0d]", i), got[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    int c;
    bit hit;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {aver_sent, rd_req0, rd_req1, recirc_wr0, recirc_wr1,
                            out_sel, dout_valid, sop, eop}, 0);
    reset = 1'b0;
    idle(3);

    // First handshake, ready_to_continue held until the sink sees aver_sent.
    fill_lines();
    build_exp();
    got.delete();
    load(0, 0);
    load(1, 1);
    run_handshake(1'b1, 1'b0, 100);
    idle(4);
    check("f1_beats", got.size(), 1 + 2 * W);
    check("f1_q0_empty", q0.size(), 0);
    check("f1_q1_size", q1.size(), W);
    for (int j = 0; j < W && j < q1.size(); j++) check($sformatf("f1_q1[%0d]", j), q1[j], ln[1][j]);
    check("f1_aver_cnt", n_aver, 1);

    // Second handshake closes the field, with random backpressure.
    load(0, 2);
    run_handshake(1'b0, 1'b1, 400);
    idle(4);
    compare_frame();
    check("f2_q0_empty", q0.size(), 0);
    check("f2_q1_empty", q1.size(), 0);
    check("f2_aver_cnt", n_aver, 2);

    // Reset at px=2 of the second AVER line, while buffer 1 is the older one.
    fill_lines();
    got.delete();
    load(0, 0);
    load(1, 1);
    run_handshake(1'b0, 1'b0, 100);
    load(0, 2);
    ready_to_continue = 1'b1;
    c = 0;
    hit = 0;
    while (c < 100) begin
      dout_ready = 1'b1;
      if (c == 1) ready_to_continue = 1'b0;
      #1;
      if (dout_valid && out_sel == 2'd2 && n_sel2() == W + 2) begin
        hit = 1;
        break;
      end
      observe();
      @(posedge clock);
      #1;
      c++;
    end
    check("reached_aver_px2", hit, 1);
    reset = 1'b1;
    ready_to_continue = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_outputs", {aver_sent, rd_req0, rd_req1, recirc_wr0, recirc_wr1,
                             out_sel, dout_valid, sop, eop}, 0);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    got.delete();
    prev_stall = 0;
    n_aver = 0;
    idle(2);

    // Full field after reset: header returns and buffer 0 is older again.
    fill_lines();
    build_exp();
    load(0, 0);
    load(1, 1);
    run_handshake(1'b0, 1'b1, 400);
    idle(2);
    load(0, 2);
    run_handshake(1'b1, 1'b1, 400);
    idle(4);
    compare_frame();
    check("f3_q0_empty", q0.size(), 0);
    check("f3_q1_empty", q1.size(), 0);
    check("f3_aver_cnt", n_aver, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deint_line_sched.md
Name: deint_line_sched

Overview:
- Read-side scheduler for the deinterlacer's two line FIFOs (buffer 0, buffer 1).
- The sink fills the FIFOs alternately and raises ready_to_continue.
- This block sequences FIFO reads and write-back (recirculation) and drives the output mux select. It also drives the Avalon-ST output control signals and returns aver_sent to the sink.
- Output order per field: L0, avg(L0,L1), L1, avg(L1,L2), …, L(H-1), L(H-1); 2*HALF_HEIGHT lines per frame.

Parameters:
- WIDTH, 720, pixels per line.
- HALF_HEIGHT, 240, lines per field (H).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ready_to_continue  in  1  sink has a new line in the non-older buffer.
- aver_sent  out  1  one-cycle pulse releasing the sink.
- rd_req0  out  1  pop FIFO 0 (show-ahead, data valid same cycle).
- rd_req1  out  1  pop FIFO 1.
- recirc_wr0  out  1  write popped FIFO 0 word back into FIFO 0.
- recirc_wr1  out  1  write popped FIFO 1 word back into FIFO 1.
- out_sel  out  2  datapath mux: 0 = header word 0, 1 = older buffer, 2 = average, 3 = newer buffer.
- dout_valid  out  1  Avalon-ST valid.
- dout_ready  in  1  Avalon-ST ready, ready latency 0.
- dout_startofpacket  out  1  SOP.
- dout_endofpacket  out  1  EOP.

Behaviour:
- Reset: all outputs 0; state IDLE; older=buff0; px=0; pair_cnt=0; hdr_done=0.
- Beat = dout_valid & dout_ready. All pops and recirc writes are qualified by beat, so they fire in the same cycle as the beat.
- px is a 10-bit pixel counter; it wraps WIDTH-1 -> 0 at the end of each line.
- pair_cnt is a 10-bit counter of handshakes completed in the current frame.

State machine:
- IDLE:
  - Wait for ready_to_continue.
  - If hdr_done=0, go to HDR; otherwise go to ORIG.
- HDR:
  - dout_valid=1, out_sel=0, SOP=1.
  - On beat: hdr_done<=1, go to ORIG.
- ORIG:
  - dout_valid=1, out_sel=1.
  - On beat: pop the older FIFO and recirculate it to itself.
  - At px=WIDTH-1 with beat: go to AVER.
- AVER:
  - dout_valid=1, out_sel=2.
  - On beat: pop both FIFOs; recirculate the newer FIFO only. The older FIFO drains to empty.
  - At px=WIDTH-1 with beat:
    - pair_cnt+1;
    - if pair_cnt+1 == H-1, go to TAIL_A;
    - else pulse aver_sent, toggle older, go to IDLE.
- TAIL_A:
  - out_sel=3; pop the newer FIFO and recirculate it.
  - At end of line: go to TAIL_B.
- TAIL_B:
  - out_sel=3; pop the newer FIFO, no recirculation; EOP on px=WIDTH-1.
  - At end of line: pulse aver_sent, older<=buff0, pair_cnt<=0, hdr_done<=0, go to IDLE.
  - Both FIFOs are now empty, ready for the sink's next frame, whose first line goes to buff0.
- Older/newer encoding: older=buff0 means rd_req0 is the "older" strobe and buff1 is the newer buffer.
- Stall: dout_ready=0 holds all outputs and counters; no pop or recirc is issued.
- aver_sent: exactly one cycle, registered, issued in the cycle after the final beat. The sink drops ready_to_continue on that pulse, so IDLE must not re-sample ready_to_continue in the pulse cycle.
- ready_to_continue outside IDLE is ignored.
- H=1: the first handshake is also the last.
- Reset mid-line: returns to IDLE immediately. The FIFOs are cleared externally by the same reset.

Optional Feature:
- Macro DEINT_SCHED_EMPTY_CHK_EN.
- When defined, add inputs empty0 and empty1 and output underflow_err (1 bit, sticky, cleared by reset).
  - dout_valid is forced to 0 while any FIFO due to be popped in the current state is empty.
  - If a pop would occur on an empty FIFO, underflow_err<=1.
- When undefined: no extra ports; FIFO occupancy is assumed correct by construction.

Test Plan:
- WIDTH=4, H=3; FIFO0 preloaded with pixels 10..13, FIFO1 with 20..23; pulse ready_to_continue, dout_ready=1 -> expect:
  - header beat with SOP;
  - 4 beats with out_sel=1 and rd_req0;
  - 4 beats with out_sel=2 and rd_req0 & rd_req1, recirc_wr1=1;
  - aver_sent 1 cycle; FIFO0 empty, FIFO1 still holds 20..23.
- Second handshake (FIFO0 refilled with 30..33) -> expect:
  - no header;
  - ORIG pops FIFO1;
  - AVER pops both with recirc_wr0;
  - then TAIL_A and TAIL_B from FIFO0, EOP on the 4th TAIL_B beat;
  - aver_sent; both FIFOs empty; total 24 output beats plus the header.
- dout_ready toggled 1,0,0,1 during AVER -> no pops while low; pixel order unchanged; px does not advance.
- ready_to_continue held high during ORIG -> no second sequence starts; exactly one aver_sent per handshake.
- Reset asserted at px=2 of AVER -> next cycle all outputs 0, state IDLE, older=buff0.
- With DEINT_SCHED_EMPTY_CHK_EN defined, empty1=1 during AVER -> dout_valid=0 and no pops; underflow_err stays 0. Forcing rd_req1 via a bad preload raises underflow_err=1 until reset.
